// File: rtl/scaler_mode_pkg.sv
// Mode encodings and per-mode crop/resolution table for the scaler mode controller.
// Latency: none, combinational constants and a lookup function only.
// Backpressure: none, no handshaking.
package scaler_mode_pkg;

    typedef enum logic [1:0] {
        MODE_FULL    = 2'd0,
        MODE_CROP768 = 2'd1,
        MODE_CROP512 = 2'd2,
        MODE_HALF    = 2'd3
    } mode_t;

    localparam int CFG_IN_W  = 11;
    localparam int CFG_OUT_W = 12;

    localparam logic [CFG_IN_W-1:0]  IN_X_RES      = 11'd1024;
    localparam logic [CFG_IN_W-1:0]  IN_Y_RES      = 11'd768;
    localparam logic [CFG_IN_W-1:0]  X_END_FULL    = 11'd1023;
    localparam logic [CFG_IN_W-1:0]  X_END_CROP768 = 11'd767;
    localparam logic [CFG_IN_W-1:0]  X_END_CROP512 = 11'd511;
    localparam logic [CFG_IN_W-1:0]  Y_END_ALL     = 11'd767;
    localparam logic [CFG_OUT_W-1:0] OUT_X_FULL    = 12'd1024;
    localparam logic [CFG_OUT_W-1:0] OUT_Y_FULL    = 12'd768;
    localparam logic [CFG_OUT_W-1:0] OUT_X_HALF    = 12'd512;
    localparam logic [CFG_OUT_W-1:0] OUT_Y_HALF    = 12'd384;

    typedef struct packed {
        logic [CFG_IN_W-1:0]  xBgn;
        logic [CFG_IN_W-1:0]  xEnd;
        logic [CFG_IN_W-1:0]  yBgn;
        logic [CFG_IN_W-1:0]  yEnd;
        logic [CFG_IN_W-1:0]  inXRes;
        logic [CFG_IN_W-1:0]  inYRes;
        logic [CFG_OUT_W-1:0] outXRes;
        logic [CFG_OUT_W-1:0] outYRes;
    } modeCfg_t;

    function automatic modeCfg_t modeCfg(input mode_t m);
        modeCfg_t cfg;
        cfg.xBgn    = '0;
        cfg.yBgn    = '0;
        cfg.xEnd    = X_END_FULL;
        cfg.yEnd    = Y_END_ALL;
        cfg.inXRes  = IN_X_RES;
        cfg.inYRes  = IN_Y_RES;
        cfg.outXRes = OUT_X_FULL;
        cfg.outYRes = OUT_Y_FULL;
        case (m)
            MODE_CROP768: cfg.xEnd = X_END_CROP768;
            MODE_CROP512: cfg.xEnd = X_END_CROP512;
            MODE_HALF: begin
                cfg.outXRes = OUT_X_HALF;
                cfg.outYRes = OUT_Y_HALF;
            end
            default: ;
        endcase
        return cfg;
    endfunction

endpackage

// File: rtl/scaler_btn_debounce.sv
// Button synchronizer + stable-level debouncer emitting a one-cycle press pulse on a debounced rise.
// Latency: raw rise held stable -> pressEvt DEBOUNCE_CYCLES+2 cycles later.
// Backpressure: none, events are fire-and-forget pulses.
module scaler_btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_WIDTH       = 20
) (
    input  logic clka,
    input  logic rst,
    input  logic btn,
    output logic pressEvt
);

    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

    logic                 sync1;
    logic                 sync2;
    logic                 db;
    logic [CNT_WIDTH-1:0] cnt;

    always_ff @(posedge clka) begin
        if (rst) begin
            sync1    <= 1'b0;
            sync2    <= 1'b0;
            db       <= 1'b0;
            cnt      <= '0;
            pressEvt <= 1'b0;
        end else begin
            sync1    <= btn;
            sync2    <= sync1;
            pressEvt <= 1'b0;
            // Any sample matching the accepted level restarts the stability count.
            if (sync2 == db) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                db       <= sync2;
                cnt      <= '0;
                pressEvt <= sync2;
            end else begin
                cnt <= cnt + CNT_WIDTH'(1);
            end
        end
    end

endmodule

// File: rtl/scaler_mode_ctrl.sv
// Button-driven scaler mode controller; SCALER_MODE_FRAME_SYNC_EN defers mode loads to iVsyn frame edges.
// Latency: frame mode 4 cycles iVsyn rise -> outputs; direct mode 1 cycle press event -> outputs.
// Backpressure: none, last request wins while one is pending.
module scaler_mode_ctrl
    import scaler_mode_pkg::*;
#(
    parameter int INPUT_RES_WIDTH  = 11,
    parameter int OUTPUT_RES_WIDTH = 11,
    parameter int DEBOUNCE_CYCLES  = 500000,
    parameter int CNT_WIDTH        = 20
) (
    input  logic                        clka,
    input  logic                        rst,
    input  logic                        button2,
    input  logic                        button3,
    input  logic                        button4,
    input  logic                        iVsyn,
    output logic [INPUT_RES_WIDTH-1:0]  xBgn,
    output logic [INPUT_RES_WIDTH-1:0]  xEnd,
    output logic [INPUT_RES_WIDTH-1:0]  yBgn,
    output logic [INPUT_RES_WIDTH-1:0]  yEnd,
    output logic [INPUT_RES_WIDTH-1:0]  inXRes,
    output logic [INPUT_RES_WIDTH-1:0]  inYRes,
    output logic [OUTPUT_RES_WIDTH:0]   outXRes,
    output logic [OUTPUT_RES_WIDTH:0]   outYRes,
    output logic [1:0]                  modeIdx,
    output logic                        cfgPending,
    output logic                        cfgUpdate
);

    logic     press2, press3, press4;
    logic     reqVld;
    mode_t    reqMode;
    logic     applyEn;
    mode_t    nextMode;
    mode_t    curMode;
    modeCfg_t nextCfg;
    modeCfg_t rstCfg;

    scaler_btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_WIDTH(CNT_WIDTH)) u_db2 (
        .clka(clka), .rst(rst), .btn(button2), .pressEvt(press2));
    scaler_btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_WIDTH(CNT_WIDTH)) u_db3 (
        .clka(clka), .rst(rst), .btn(button3), .pressEvt(press3));
    scaler_btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_WIDTH(CNT_WIDTH)) u_db4 (
        .clka(clka), .rst(rst), .btn(button4), .pressEvt(press4));

    always_comb begin
        reqVld  = press2 | press3 | press4;
        reqMode = MODE_HALF;
        if (press2)      reqMode = MODE_CROP768;
        else if (press3) reqMode = MODE_CROP512;
    end

`ifdef SCALER_MODE_FRAME_SYNC_EN
    logic  vsSync1, vsSync2, vsPrev, frameEdge;
    logic  pendVld;
    mode_t pendMode;

    always_ff @(posedge clka) begin
        if (rst) begin
            vsSync1   <= 1'b0;
            vsSync2   <= 1'b0;
            vsPrev    <= 1'b0;
            frameEdge <= 1'b0;
        end else begin
            vsSync1   <= iVsyn;
            vsSync2   <= vsSync1;
            vsPrev    <= vsSync2;
            frameEdge <= vsSync2 & ~vsPrev;
        end
    end

    // A press coinciding with an apply becomes the next pending request; the apply uses the old one.
    always_ff @(posedge clka) begin
        if (rst) begin
            pendVld  <= 1'b0;
            pendMode <= MODE_FULL;
        end else if (reqVld) begin
            pendVld  <= 1'b1;
            pendMode <= reqMode;
        end else if (frameEdge) begin
            pendVld  <= 1'b0;
        end
    end

    assign applyEn    = frameEdge & pendVld;
    assign nextMode   = pendMode;
    assign cfgPending = pendVld;
`else
    logic unusedVsyn;
    assign unusedVsyn = iVsyn;
    assign applyEn    = reqVld;
    assign nextMode   = reqMode;
    assign cfgPending = 1'b0;
`endif

    assign nextCfg = modeCfg(nextMode);
    assign rstCfg  = modeCfg(MODE_FULL);
    assign modeIdx = curMode;

    always_ff @(posedge clka) begin
        if (rst) begin
            curMode   <= MODE_FULL;
            cfgUpdate <= 1'b0;
            xBgn      <= INPUT_RES_WIDTH'(rstCfg.xBgn);
            xEnd      <= INPUT_RES_WIDTH'(rstCfg.xEnd);
            yBgn      <= INPUT_RES_WIDTH'(rstCfg.yBgn);
            yEnd      <= INPUT_RES_WIDTH'(rstCfg.yEnd);
            inXRes    <= INPUT_RES_WIDTH'(rstCfg.inXRes);
            inYRes    <= INPUT_RES_WIDTH'(rstCfg.inYRes);
            outXRes   <= (OUTPUT_RES_WIDTH+1)'(rstCfg.outXRes);
            outYRes   <= (OUTPUT_RES_WIDTH+1)'(rstCfg.outYRes);
        end else begin
            cfgUpdate <= applyEn && (nextMode != curMode);
            if (applyEn) begin
                curMode <= nextMode;
                xBgn    <= INPUT_RES_WIDTH'(nextCfg.xBgn);
                xEnd    <= INPUT_RES_WIDTH'(nextCfg.xEnd);
                yBgn    <= INPUT_RES_WIDTH'(nextCfg.yBgn);
                yEnd    <= INPUT_RES_WIDTH'(nextCfg.yEnd);
                inXRes  <= INPUT_RES_WIDTH'(nextCfg.inXRes);
                inYRes  <= INPUT_RES_WIDTH'(nextCfg.inYRes);
                outXRes <= (OUTPUT_RES_WIDTH+1)'(nextCfg.outXRes);
                outYRes <= (OUTPUT_RES_WIDTH+1)'(nextCfg.outYRes);
            end
        end
    end

endmodule

// File: tb/tb_scaler_mode_ctrl.sv
// Scoreboard bench for scaler_mode_ctrl: expected mode changes are queued at stimulus time and
// popped by a monitor on every cfgUpdate pulse; works with the frame-sync macro defined or not.
module tb_scaler_mode_ctrl;

    localparam int DB = 4;
`ifdef SCALER_MODE_FRAME_SYNC_EN
    localparam bit SYNC_EN = 1'b1;
`else
    localparam bit SYNC_EN = 1'b0;
`endif

    logic        clka = 1'b0;
    logic        rst = 1'b1;
    logic        button2 = 1'b0, button3 = 1'b0, button4 = 1'b0;
    logic        iVsyn = 1'b0;
    logic [10:0] xBgn, xEnd, yBgn, yEnd, inXRes, inYRes;
    logic [11:0] outXRes, outYRes;
    logic [1:0]  modeIdx;
    logic        cfgPending, cfgUpdate;

    scaler_mode_ctrl #(
        .INPUT_RES_WIDTH(11), .OUTPUT_RES_WIDTH(11), .DEBOUNCE_CYCLES(DB), .CNT_WIDTH(20)
    ) dut (
        .clka(clka), .rst(rst), .button2(button2), .button3(button3), .button4(button4),
        .iVsyn(iVsyn), .xBgn(xBgn), .xEnd(xEnd), .yBgn(yBgn), .yEnd(yEnd),
        .inXRes(inXRes), .inYRes(inYRes), .outXRes(outXRes), .outYRes(outYRes),
        .modeIdx(modeIdx), .cfgPending(cfgPending), .cfgUpdate(cfgUpdate)
    );

    always #5 clka = ~clka;

    int cycleCount = 0;
    always @(posedge clka) cycleCount <= cycleCount + 1;

    int tests = 0;
    int fails = 0;

    typedef struct { int mode; int cyc; } exp_t;
    exp_t sbq[$];

    // Reference model state: active mode and the outstanding request.
    int  mMode    = 0;
    int  mPend    = 0;
    bit  mPendVld = 1'b0;

    // Mode table straight from the datasheet.
    function automatic int tXEnd(int m);
        return (m == 1) ? 767 : (m == 2) ? 511 : 1023;
    endfunction
    function automatic int tOutX(int m);
        return (m == 3) ? 512 : 1024;
    endfunction
    function automatic int tOutY(int m);
        return (m == 3) ? 384 : 768;
    endfunction

    task automatic chk(input string name, input int act, input int expv);
        tests++;
        if (act != expv) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cycleCount);
        end
    endtask

    task automatic chkOutputs(input string tag, input int m);
        chk({tag, " modeIdx"}, int'(modeIdx), m);
        chk({tag, " xEnd"}, int'(xEnd), tXEnd(m));
        chk({tag, " yEnd"}, int'(yEnd), 767);
        chk({tag, " xBgn+yBgn"}, int'(xBgn) + int'(yBgn), 0);
        chk({tag, " inXRes"}, int'(inXRes), 1024);
        chk({tag, " inYRes"}, int'(inYRes), 768);
        chk({tag, " outXRes"}, int'(outXRes), tOutX(m));
        chk({tag, " outYRes"}, int'(outYRes), tOutY(m));
    endtask

    // Monitor: every cfgUpdate pulse must match the oldest expected mode change, on its cycle.
    always @(negedge clka) begin
        if (cfgUpdate === 1'b1) begin
            if (sbq.size() == 0) begin
                chk("spurious cfgUpdate", int'(cfgUpdate), 0);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                chk("update cycle", cycleCount, e.cyc);
                chkOutputs("update", e.mode);
            end
        end
    end

    // mask bit0=button2, bit1=button3, bit2=button4, all rising together.
    task automatic pressBtn(input int mask);
        int c, hold, winner;
        bit prevPend;
        hold     = DB + 3 + $urandom_range(0, 4);
        winner   = mask[0] ? 1 : mask[1] ? 2 : 3;
        prevPend = mPendVld;
        @(negedge clka);
        button2 = mask[0];
        button3 = mask[1];
        button4 = mask[2];
        c = cycleCount;
        if (SYNC_EN) begin
            mPend    = winner;
            mPendVld = 1'b1;
        end else begin
            if (winner != mMode) sbq.push_back('{winner, c + DB + 3});
            mMode = winner;
        end
        for (int i = 1; i <= hold; i++) begin
            @(negedge clka);
            if (i == DB + 2) chk("pending before press", int'(cfgPending), SYNC_EN ? int'(prevPend) : 0);
            if (i == DB + 3) chk("pending after press", int'(cfgPending), SYNC_EN ? 1 : 0);
        end
        button2 = 1'b0;
        button3 = 1'b0;
        button4 = 1'b0;
        repeat (DB + 6) @(negedge clka);
    endtask

    task automatic glitchBtn(input int mask, input int len);
        @(negedge clka);
        button2 = mask[0];
        button3 = mask[1];
        button4 = mask[2];
        repeat (len) @(negedge clka);
        button2 = 1'b0;
        button3 = 1'b0;
        button4 = 1'b0;
        repeat (DB + 6) @(negedge clka);
        chk("glitch pending", int'(cfgPending), int'(mPendVld));
        chk("glitch mode", int'(modeIdx), mMode);
    endtask

    task automatic frame();
        @(negedge clka);
        iVsyn = 1'b1;
        if (SYNC_EN && mPendVld) begin
            if (mPend != mMode) sbq.push_back('{mPend, cycleCount + 4});
            mMode    = mPend;
            mPendVld = 1'b0;
        end
        repeat (6) @(negedge clka);
        iVsyn = 1'b0;
        repeat (4) @(negedge clka);
        chk("frame mode", int'(modeIdx), mMode);
        chk("frame pending", int'(cfgPending), int'(mPendVld));
    endtask

    task automatic doReset();
        @(negedge clka);
        rst = 1'b1;
        @(negedge clka);
        chk("reset pending", int'(cfgPending), 0);
        chk("reset update", int'(cfgUpdate), 0);
        chkOutputs("reset", 0);
        @(negedge clka);
        rst      = 1'b0;
        mMode    = 0;
        mPendVld = 1'b0;
    endtask

    initial begin
        repeat (3) @(negedge clka);
        rst = 1'b0;
        chkOutputs("initial", 0);
        chk("initial pending", int'(cfgPending), 0);

        glitchBtn(3'b010, 2);

        pressBtn(3'b010);
        frame();

        pressBtn(3'b101);
        frame();
        chk("priority xEnd", int'(xEnd), tXEnd(mMode));

        pressBtn(3'b100);
        pressBtn(3'b001);
        frame();
        pressBtn(3'b010);
        doReset();
        frame();

        for (int n = 0; n < 24; n++) begin
            int op;
            op = $urandom_range(0, 9);
            if (op <= 4)      pressBtn($urandom_range(1, 7));
            else if (op <= 7) frame();
            else if (op == 8) glitchBtn($urandom_range(1, 7), $urandom_range(1, DB - 1));
            else              doReset();
        end
        frame();

        repeat (10) @(negedge clka);
        chk("scoreboard drained", sbq.size(), 0);
        chkOutputs("final", mMode);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
